// File: rtl/tetris_pkg.sv
// Shared types and defaults for the tetron datapath: board size, offset width,
// checker FSM states and the signed cell-coordinate type.
package tetris_pkg;

   localparam int DEF_BOARD_W = 10;
   localparam int DEF_BOARD_H = 20;
   localparam int OFS_W       = 5;
   localparam int CELL_W      = 7;

   typedef enum logic [1:0] {StIdle, StAddr, StData, StDone} state_t;

   typedef logic signed [CELL_W-1:0] cell_t;

   // Unsigned anchor plus two's-complement offset, widened so neither side can overflow.
   function automatic cell_t cell_sum(input logic [OFS_W-1:0] anchor,
                                      input logic [OFS_W-1:0] ofs);
      return cell_t'({{(CELL_W-OFS_W){1'b0}}, anchor}) +
             cell_t'({{(CELL_W-OFS_W){ofs[OFS_W-1]}}, ofs});
   endfunction

endpackage

// File: rtl/tetron_cell_calc.sv
// Combinational anchor+offset to absolute board cell for one block: bounds flag
// and linear RAM address (row*BOARD_W+col).
module tetron_cell_calc
   import tetris_pkg::*;
#(
   parameter int BOARD_W = DEF_BOARD_W,
   parameter int BOARD_H = DEF_BOARD_H,
   parameter int ADDR_W  = 8
) (
   input  logic [OFS_W-1:0]  row,
   input  logic [OFS_W-1:0]  col,
   input  logic [OFS_W-1:0]  voffset,
   input  logic [OFS_W-1:0]  hoffset,
   output logic              oob,
   output logic [ADDR_W-1:0] addr
);

   cell_t r;
   cell_t c;

   always_comb begin
      r    = cell_sum(row, voffset);
      c    = cell_sum(col, hoffset);
      // Negative row means above the top edge, which also counts as a collision.
      oob  = r[CELL_W-1] || c[CELL_W-1] ||
             (r >= cell_t'(BOARD_H)) || (c >= cell_t'(BOARD_W));
      addr = ADDR_W'(int'(r) * BOARD_W + int'(c));
   end

endmodule

// File: rtl/tetron_collision_checker.sv
// Walks the four blocks of a latched piece, bounds-checks each cell and reads the
// board RAM, stopping at the first hit. Optional TETRON_COLLIDE_INDEX_EN adds collide_idx.
module tetron_collision_checker
   import tetris_pkg::*;
#(
   parameter int BOARD_W = DEF_BOARD_W,
   parameter int BOARD_H = DEF_BOARD_H,
   parameter int ADDR_W  = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [OFS_W-1:0]  piece_row,
   input  logic [OFS_W-1:0]  piece_col,
   input  logic [OFS_W-1:0]  blk1_voffset,
   input  logic [OFS_W-1:0]  blk2_voffset,
   input  logic [OFS_W-1:0]  blk3_voffset,
   input  logic [OFS_W-1:0]  blk4_voffset,
   input  logic [OFS_W-1:0]  blk1_hoffset,
   input  logic [OFS_W-1:0]  blk2_hoffset,
   input  logic [OFS_W-1:0]  blk3_hoffset,
   input  logic [OFS_W-1:0]  blk4_hoffset,
   output logic              board_re,
   output logic [ADDR_W-1:0] board_raddr,
   input  logic              board_rdata,
   output logic              busy,
   output logic              done,
   output logic              collide
`ifdef TETRON_COLLIDE_INDEX_EN
   ,
   output logic [1:0]        collide_idx
`endif
);

   state_t            state;
   logic [1:0]        idx;
   logic [OFS_W-1:0]  row_q;
   logic [OFS_W-1:0]  col_q;
   logic [OFS_W-1:0]  voff_q [4];
   logic [OFS_W-1:0]  hoff_q [4];

   logic              cell_oob;
   logic [ADDR_W-1:0] cell_addr;
   logic              hit;
   logic              finish;

   tetron_cell_calc #(
      .BOARD_W (BOARD_W),
      .BOARD_H (BOARD_H),
      .ADDR_W  (ADDR_W)
   ) u_cell_calc (
      .row     (row_q),
      .col     (col_q),
      .voffset (voff_q[idx]),
      .hoffset (hoff_q[idx]),
      .oob     (cell_oob),
      .addr    (cell_addr)
   );

   always_comb begin
      board_re    = (state == StAddr) && !cell_oob;
      board_raddr = board_re ? cell_addr : '0;
      hit         = ((state == StAddr) && cell_oob) || ((state == StData) && board_rdata);
      finish      = hit || ((state == StData) && (idx == 2'd3));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= StIdle;
         idx     <= 2'd0;
         busy    <= 1'b0;
         done    <= 1'b0;
         collide <= 1'b0;
         row_q   <= '0;
         col_q   <= '0;
         for (int i = 0; i < 4; i++) begin
            voff_q[i] <= '0;
            hoff_q[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         unique case (state)
            // DONE behaves like IDLE for start so a back-to-back request is not lost.
            StIdle, StDone: begin
               if (start) begin
                  row_q     <= piece_row;
                  col_q     <= piece_col;
                  voff_q[0] <= blk1_voffset;
                  voff_q[1] <= blk2_voffset;
                  voff_q[2] <= blk3_voffset;
                  voff_q[3] <= blk4_voffset;
                  hoff_q[0] <= blk1_hoffset;
                  hoff_q[1] <= blk2_hoffset;
                  hoff_q[2] <= blk3_hoffset;
                  hoff_q[3] <= blk4_hoffset;
                  idx       <= 2'd0;
                  busy      <= 1'b1;
                  state     <= StAddr;
               end else begin
                  state <= StIdle;
               end
            end
            StAddr, StData: begin
               if (finish) begin
                  collide <= hit;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state   <= StDone;
               end else if (state == StAddr) begin
                  state <= StData;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= StAddr;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

`ifdef TETRON_COLLIDE_INDEX_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         collide_idx <= 2'd0;
      end else if (finish) begin
         collide_idx <= hit ? idx : 2'd0;
      end
   end
`endif

endmodule

// File: tb/tb_tetron_collision_checker.sv
// Scoreboard bench for tetron_collision_checker: a behavioural model predicts reads,
// verdict and done cycle per check; a negedge monitor compares what the DUT presents.
module tb_tetron_collision_checker;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [4:0] piece_row = '0;
   logic [4:0] piece_col = '0;
   logic [4:0] vo [4];
   logic [4:0] ho [4];
   logic       board_re;
   logic [7:0] board_raddr;
   logic       board_rdata = 1'b0;
   logic       busy;
   logic       done;
   logic       collide;
`ifdef TETRON_COLLIDE_INDEX_EN
   logic [1:0] collide_idx;
`endif

   always #5 clk = ~clk;

   tetron_collision_checker dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .piece_row    (piece_row),
      .piece_col    (piece_col),
      .blk1_voffset (vo[0]),
      .blk2_voffset (vo[1]),
      .blk3_voffset (vo[2]),
      .blk4_voffset (vo[3]),
      .blk1_hoffset (ho[0]),
      .blk2_hoffset (ho[1]),
      .blk3_hoffset (ho[2]),
      .blk4_hoffset (ho[3]),
      .board_re     (board_re),
      .board_raddr  (board_raddr),
      .board_rdata  (board_rdata),
      .busy         (busy),
      .done         (done),
      .collide      (collide)
`ifdef TETRON_COLLIDE_INDEX_EN
      ,
      .collide_idx  (collide_idx)
`endif
   );

   typedef struct {
      int     collide;
      int     idx;
      int     nreads;
      longint done_cyc;
   } exp_t;

   exp_t   exp_q[$];
   int     addr_q[$];
   logic   occ [256];
   longint cyc = 0;
   int     tests = 0;
   int     fails = 0;
   int     reads_seen = 0;
   int     held = 0;
   exp_t   mon_e;

   task automatic chk(input string name, input longint act, input longint exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Board RAM: one-cycle read latency.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      board_rdata <= board_re ? occ[board_raddr] : 1'b0;
   end

   always @(negedge clk) begin
      if (rst_n) begin
         if (board_re) begin
            reads_seen++;
            if (addr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL extra_read: got addr %0d, expected no read", board_raddr);
            end else begin
               chk("raddr", board_raddr, addr_q.pop_front());
            end
         end
         if (done) begin
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL spurious_done: got done=1, expected 0 (cycle %0d)", cyc);
            end else begin
               mon_e = exp_q.pop_front();
               chk("collide", collide, mon_e.collide);
               chk("done_cycle", cyc, mon_e.done_cyc);
               chk("nreads", reads_seen, mon_e.nreads);
               chk("busy_at_done", busy, 0);
`ifdef TETRON_COLLIDE_INDEX_EN
               chk("collide_idx", collide_idx, mon_e.idx);
`endif
               held = mon_e.collide;
            end
            reads_seen = 0;
         end else begin
            chk("collide_held", collide, held);
         end
      end
   end

   // Reference: walk blocks in order, stop at first out-of-bounds or occupied cell.
   task automatic launch();
      exp_t e;
      int   r;
      int   c;
      int   lat;
      e.collide = 0;
      e.idx     = 0;
      e.nreads  = 0;
      lat       = 8;
      for (int i = 0; i < 4; i++) begin
         r = int'(piece_row) + int'($signed(vo[i]));
         c = int'(piece_col) + int'($signed(ho[i]));
         if (r < 0 || r >= 20 || c < 0 || c >= 10) begin
            e.collide = 1;
            e.idx     = i;
            lat       = 2 * i + 1;
            break;
         end
         addr_q.push_back(r * 10 + c);
         e.nreads++;
         if (occ[r * 10 + c]) begin
            e.collide = 1;
            e.idx     = i;
            lat       = 2 * i + 2;
            break;
         end
      end
      e.done_cyc = cyc + 1 + lat;
      exp_q.push_back(e);
      start = 1'b1;
   endtask

   task automatic wait_done();
      int n = 0;
      while (!done && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         tests++;
         fails++;
         $display("FAIL done_timeout: got no done, expected done within 40 cycles");
      end
   endtask

   task automatic run_one();
      launch();
      @(negedge clk);
      start = 1'b0;
      chk("busy_running", busy, 1);
      wait_done();
      @(negedge clk);
   endtask

   task automatic set_piece(input int row, input int col, input int v0, input int h0,
                            input int v1, input int h1, input int v2, input int h2,
                            input int v3, input int h3);
      piece_row = 5'(row);
      piece_col = 5'(col);
      vo[0] = 5'(v0);
      ho[0] = 5'(h0);
      vo[1] = 5'(v1);
      ho[1] = 5'(h1);
      vo[2] = 5'(v2);
      ho[2] = 5'(h2);
      vo[3] = 5'(v3);
      ho[3] = 5'(h3);
   endtask

   task automatic rand_piece();
      int t;
      piece_row = 5'($urandom_range(0, 21));
      piece_col = 5'($urandom_range(0, 11));
      for (int i = 0; i < 4; i++) begin
         t = int'($urandom_range(0, 4)) - 2;
         vo[i] = 5'(t);
         t = int'($urandom_range(0, 4)) - 2;
         ho[i] = 5'(t);
         if ($urandom_range(0, 7) == 0) vo[i] = 5'($urandom);
      end
   endtask

   task automatic rand_board(input int density);
      for (int a = 0; a < 256; a++) occ[a] = ($urandom_range(0, 99) < density);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish, expected finish before 200000 time units");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 256; a++) occ[a] = 1'b0;
      set_piece(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_collide", collide, 0);
      chk("rst_board_re", board_re, 0);
      chk("rst_raddr", board_raddr, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Empty board: reads 54,55,53,64 and no collision.
      set_piece(5, 4, 0, 0, 0, 1, 0, -1, 1, 0);
      run_one();
      // Cell 55 occupied: two reads, collision on block index 1.
      occ[55] = 1'b1;
      run_one();
      occ[55] = 1'b0;
      // Block 1 above the top edge.
      set_piece(0, 4, -1, 0, 0, 0, 0, 0, 0, 0);
      run_one();
      // Right edge and bottom edge.
      set_piece(19, 9, 0, 0, 0, 1, 0, 0, 0, 0);
      run_one();
      set_piece(19, 9, 0, 0, 1, 0, 0, 0, 0, 0);
      run_one();

      // Start pulsed mid-check with new inputs: ignored, first inputs used.
      set_piece(5, 4, 0, 0, 0, 1, 0, -1, 1, 0);
      occ[64] = 1'b1;
      launch();
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      set_piece(0, 4, -1, 0, 0, 0, 0, 0, 0, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      repeat (4) @(negedge clk);
      occ[64] = 1'b0;

      // Start in the done cycle is accepted.
      set_piece(3, 3, 0, 0, 0, 1, 1, 0, 1, 1);
      launch();
      @(negedge clk);
      start = 1'b0;
      wait_done();
      set_piece(10, 2, 0, 0, 0, -1, 0, -2, 0, -3);
      launch();
      @(negedge clk);
      start = 1'b0;
      wait_done();
      @(negedge clk);

      // Reset mid-check aborts with outputs at reset values.
      occ[33] = 1'b1;
      set_piece(3, 3, 0, 0, 0, 1, 1, 0, 1, 1);
      run_one();
      occ[33] = 1'b0;
      set_piece(5, 4, 0, 0, 0, 1, 0, -1, 1, 0);
      launch();
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_collide", collide, 0);
      chk("abort_board_re", board_re, 0);
      exp_q.delete();
      addr_q.delete();
      reads_seen = 0;
      held = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run_one();

      // Randomised checks on random boards.
      for (int n = 0; n < 80; n++) begin
         if (n % 10 == 0) rand_board(int'($urandom_range(5, 30)));
         rand_piece();
         run_one();
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      repeat (3) @(negedge clk);
      chk("leftover_results", exp_q.size(), 0);
      chk("leftover_reads", addr_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/tetron_collision_checker.md
Name: tetron_collision_checker

Overview:
- Downstream of the tetron shaper.
- Takes a piece anchor position plus the four per-block signed offsets from the shaper, and computes each block's absolute board cell.
- For each cell, checks the board bounds and reads the occupancy RAM.
- Reports a single collide/no-collide verdict to the game-control FSM, which uses it to accept or reject a move, rotation or drop.

Parameters:
- BOARD_W, 10, board width in cells (columns 0..BOARD_W-1).
- BOARD_H, 20, board height in cells (rows 0..BOARD_H-1, row 0 = top).
- ADDR_W, 8, board RAM address width; must satisfy 2**ADDR_W >= BOARD_W*BOARD_H.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request a check; sampled only in IDLE.
- piece_row  in  5  anchor row, unsigned.
- piece_col  in  5  anchor column, unsigned.
- blk1_voffset..blk4_voffset  in  5 each  row offsets, two's complement.
- blk1_hoffset..blk4_hoffset  in  5 each  column offsets, two's complement.
- board_re  out  1  board RAM read enable.
- board_raddr  out  ADDR_W  board RAM address, row*BOARD_W+col.
- board_rdata  in  1  cell occupied; valid the cycle after board_re.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse; verdict valid.
- collide  out  1  verdict; held from done until the next accepted start.

Behaviour:
- Reset (async, rst_n low): state=IDLE, busy=0, done=0, collide=0, board_re=0, board_raddr=0, index=0, all latches=0.
- Input latching: on the edge where start=1 in IDLE, latch piece_row, piece_col and all eight offsets, then go to ADDR with index=0. Later input changes are ignored until the next start.
- Start handling: start while busy is ignored. done and start in the same cycle is legal; FSM is then in IDLE and the new start is accepted.
- Cell arithmetic, per block i:
  - Work in 7-bit signed: r = zero-extended piece_row + sign-extended voffset_i; c = likewise with columns.
  - Out of bounds when r<0, r>=BOARD_H, c<0 or c>=BOARD_W. Rows above the top count as out of bounds.
- States:
  - IDLE: busy=0. Go to ADDR on start.
  - ADDR: board_re/board_raddr are combinational from state and index.
    - Cell out of bounds: collide<=1, go to DONE, no read issued (board_re=0).
    - Otherwise board_re=1, board_raddr=r*BOARD_W+c, go to DATA.
  - DATA: sample board_rdata at the end of the cycle.
    - 1: collide<=1, go to DONE.
    - 0 and index==3: collide<=0, go to DONE.
    - 0 otherwise: index+1, go to ADDR.
  - DONE: done=1 for exactly this cycle, busy=0, go to IDLE.
- Early exit: checking stops at the first colliding block; later blocks are not read.
- Latency, with start accepted at edge T:
  - No collision: done is high in cycle T+8, i.e. 4 blocks x 2 cycles, then DONE.
  - Block 1 out of bounds: done in cycle T+1.
- collide clears only on the next verdict. It is not cleared at start.
- Reset mid-check aborts immediately: no done pulse, outputs return to reset values.

Optional Feature:
- Macro: TETRON_COLLIDE_INDEX_EN.
- Defined: adds output collide_idx [1:0], registered alongside collide.
  - Holds the index (0..3) of the block that caused the collision.
  - Reset value 0; 0 when the verdict is no collision.
- Undefined: port absent; the index register is not built; all other behaviour identical.

Decomposition:
- Shared package tetris_pkg: BOARD_W/BOARD_H defaults, cell-offset width (5), the FSM state enum (IDLE/ADDR/DATA/DONE) and the 7-bit signed cell type.
- One natural sub-module, tetron_cell_calc: combinational anchor+offset to (oob, addr) for one block, instantiated once and muxed by index.

Test Plan:
- Empty board, anchor (5,4), offsets (0,0)(0,1)(0,-1)(1,0) → reads addr 54,55,53,64 in order; done in cycle T+8; collide=0.
- Same piece, RAM cell 55 occupied → exactly two reads (54, 55); done at T+4; collide=1; collide_idx=1 with macro.
- Anchor (0,4), block1 voffset=-1 → no board_re ever; done at T+1; collide=1.
- Anchor (19,9), block offset (0,1) → column 10 out of bounds; collide=1 with no read issued for that block; offset (1,0) → row 20 out of bounds; collide=1.
- start pulsed again at T+3 during a check → ignored; single done; the verdict reflects the first latched inputs even if the inputs change after T.
- rst_n low at T+5 mid-check → busy/done/collide/board_re=0 immediately; the next start runs a full clean check.
